// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - TAP/UART debug constants, debug-register addresses and write-router types
package uart_pkg;

  localparam int IRLENGTH = 5;

  localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h12;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h13;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h14;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h15;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tap_wr_state_t;

  localparam int TAP_WR_NUM_CH = 5;

  // Entry k sits at bits [k*IRLENGTH +: IRLENGTH], so DMI is channel 0.
  localparam logic [TAP_WR_NUM_CH*IRLENGTH-1:0] TAP_WR_CH_ADDR =
    {ADDR_STB1_D, ADDR_STB1_CS, ADDR_STB0_D, ADDR_STB0_CS, ADDR_DMI};

endpackage

// File: rtl/tap_write_watchdog.sv
// rtl/tap_write_watchdog.sv - wait-cycle counter with expire pulse on the last allowed cycle
module tap_write_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] count;

  // Saturates so a disabled watchdog can idle in a waiting state forever without wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/tap_write_router.sv
// rtl/tap_write_router.sv - address-decoded write router from the UART debug front-end to debug-register targets
module tap_write_router
  import uart_pkg::*;
#(
  parameter int NUM_CH      = TAP_WR_NUM_CH,
  parameter int WRITE_WIDTH = 41,
  parameter int ADDR_WIDTH  = IRLENGTH,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_ADDR = TAP_WR_CH_ADDR,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [ADDR_WIDTH-1:0]  WRITE_ADDRESS_I,
  input  logic [WRITE_WIDTH-1:0] WRITE_DATA_I,
  input  logic                   WRITE_VALID_I,
  output logic                   WRITE_READY_O,
  output logic [NUM_CH-1:0]      CH_VALID_O,
  input  logic [NUM_CH-1:0]      CH_READY_I,
  output logic [WRITE_WIDTH-1:0] CH_DATA_O,
  input  logic                   ERR_CLEAR_I,
  output logic                   ERR_UNMAPPED_O,
  output logic                   ERR_TIMEOUT_O,
  output logic [7:0]             ERR_COUNT_O
);

  tap_wr_state_t          state, state_next;
  logic [NUM_CH-1:0]      sel, sel_next;
  logic [WRITE_WIDTH-1:0] data_q, data_next;
  logic [NUM_CH-1:0]      dec_sel;
  logic                   dec_hit;
  logic                   handshake;
  logic                   accept;
  logic                   wd_clear;
  logic                   wd_enable;
  logic                   wd_expire;
  logic                   unmapped_evt;
  logic                   timeout_evt;
  logic                   ready_raw;

  // Walk downwards so the lowest matching entry is the last to overwrite.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (WRITE_ADDRESS_I == CH_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_sel = NUM_CH'(1) << k;
        dec_hit = 1'b1;
      end
    end
  end

  assign handshake     = (state == SEND) && |(sel & CH_READY_I);
  assign WRITE_READY_O = !RST_I && ready_raw;
  assign accept        = WRITE_VALID_I && WRITE_READY_O;
  assign wd_enable     = (state == SEND) && !handshake;

  tap_write_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (CLK_I),
    .rst    (RST_I),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state  <= IDLE;
      sel    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      sel    <= sel_next;
      data_q <= data_next;
    end
  end

  always_comb begin
    state_next   = state;
    sel_next     = sel;
    data_next    = data_q;
    ready_raw    = 1'b1;
    wd_clear     = 1'b0;
    unmapped_evt = 1'b0;
    timeout_evt  = 1'b0;

    case (state)
      IDLE: ready_raw = 1'b1;
      SEND: begin
        ready_raw = handshake;
        if (handshake) begin
          state_next = IDLE;
          sel_next   = '0;
        end else if (wd_expire) begin
          state_next  = IDLE;
          sel_next    = '0;
          timeout_evt = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase

    // A fresh accept overrides the completion decision above; it can only occur when ready was high.
    if (accept) begin
      if (dec_hit) begin
        state_next = SEND;
        sel_next   = dec_sel;
        data_next  = WRITE_DATA_I;
        wd_clear   = 1'b1;
      end else begin
        state_next   = IDLE;
        sel_next     = '0;
        unmapped_evt = 1'b1;
      end
    end
  end

  assign CH_VALID_O = (state == SEND) ? sel : '0;
  assign CH_DATA_O  = data_q;

  // A new error in the same cycle as a clear survives the clear.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ERR_UNMAPPED_O <= 1'b0;
      ERR_TIMEOUT_O  <= 1'b0;
      ERR_COUNT_O    <= 8'd0;
    end else if (unmapped_evt || timeout_evt) begin
      if (ERR_CLEAR_I) begin
        ERR_UNMAPPED_O <= unmapped_evt;
        ERR_TIMEOUT_O  <= timeout_evt;
        ERR_COUNT_O    <= 8'd1;
      end else begin
        ERR_UNMAPPED_O <= ERR_UNMAPPED_O | unmapped_evt;
        ERR_TIMEOUT_O  <= ERR_TIMEOUT_O | timeout_evt;
        if (ERR_COUNT_O != 8'hFF) begin
          ERR_COUNT_O <= ERR_COUNT_O + 8'd1;
        end
      end
    end else if (ERR_CLEAR_I) begin
      ERR_UNMAPPED_O <= 1'b0;
      ERR_TIMEOUT_O  <= 1'b0;
      ERR_COUNT_O    <= 8'd0;
    end
  end

endmodule

// File: tb/tb_tap_write_router.sv
// tb/tb_tap_write_router.sv - directed and random checks of tap_write_router against a transaction model
module tb_tap_write_router;
  import uart_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        RST_I;
  logic [4:0]  WRITE_ADDRESS_I;
  logic [40:0] WRITE_DATA_I;
  logic        WRITE_VALID_I;
  logic        WRITE_READY_O;
  logic [4:0]  CH_VALID_O;
  logic [4:0]  CH_READY_I;
  logic [40:0] CH_DATA_O;
  logic        ERR_CLEAR_I;
  logic        ERR_UNMAPPED_O;
  logic        ERR_TIMEOUT_O;
  logic [7:0]  ERR_COUNT_O;

  tap_write_router #(
    .TIMEOUT (TMO)
  ) dut (
    .CLK_I           (clk),
    .RST_I           (RST_I),
    .WRITE_ADDRESS_I (WRITE_ADDRESS_I),
    .WRITE_DATA_I    (WRITE_DATA_I),
    .WRITE_VALID_I   (WRITE_VALID_I),
    .WRITE_READY_O   (WRITE_READY_O),
    .CH_VALID_O      (CH_VALID_O),
    .CH_READY_I      (CH_READY_I),
    .CH_DATA_O       (CH_DATA_O),
    .ERR_CLEAR_I     (ERR_CLEAR_I),
    .ERR_UNMAPPED_O  (ERR_UNMAPPED_O),
    .ERR_TIMEOUT_O   (ERR_TIMEOUT_O),
    .ERR_COUNT_O     (ERR_COUNT_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [4:0] tbl [5];

  bit          pend;
  int          pch;
  logic [40:0] pdata;
  int          age;
  bit          m_eu;
  bit          m_et;
  int          m_cnt;

  int dut_hs_count = 0;
  int ready_low    = 0;
  int vhigh        = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [4:0] a);
    for (int k = 0; k < 5; k++) begin
      if (tbl[k] == a) return k;
    end
    return -1;
  endfunction

  task automatic check_regs();
    logic [4:0] ev;
    ev = pend ? (5'b00001 << pch) : 5'b00000;
    chk("ch_valid", 64'(CH_VALID_O), 64'(ev));
    if (pend) chk("ch_data", 64'(CH_DATA_O), 64'(pdata));
    chk("err_unmapped", 64'(ERR_UNMAPPED_O), 64'(m_eu));
    chk("err_timeout", 64'(ERR_TIMEOUT_O), 64'(m_et));
    chk("err_count", 64'(ERR_COUNT_O), 64'(m_cnt));
  endtask

  task automatic cycle(input logic [4:0] addr, input logic [40:0] data, input logic wv,
                       input logic [4:0] rdy, input logic clr);
    bit hs, er, acc, to, uev;
    int k;
    WRITE_ADDRESS_I = addr;
    WRITE_DATA_I    = data;
    WRITE_VALID_I   = wv;
    CH_READY_I      = rdy;
    ERR_CLEAR_I     = clr;
    #1;
    hs  = pend && rdy[pch];
    er  = !pend || hs;
    acc = wv && er;
    to  = pend && !hs && (age + 1 == TMO);
    k   = lookup(addr);
    uev = acc && (k < 0);
    chk("write_ready", 64'(WRITE_READY_O), 64'(er));
    if (|(CH_VALID_O & rdy)) dut_hs_count++;
    if (!WRITE_READY_O) ready_low++;
    @(posedge clk);
    #1;
    if (hs || to) pend = 1'b0;
    else if (pend) age++;
    if (acc && k >= 0) begin
      pend  = 1'b1;
      pch   = k;
      pdata = data;
      age   = 0;
    end
    if (uev || to) begin
      if (clr) begin
        m_eu  = uev;
        m_et  = to;
        m_cnt = 1;
      end else begin
        m_eu  = m_eu | uev;
        m_et  = m_et | to;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else if (clr) begin
      m_eu  = 1'b0;
      m_et  = 1'b0;
      m_cnt = 0;
    end
    if (CH_VALID_O != 5'b0) vhigh++;
    check_regs();
  endtask

  task automatic do_reset();
    RST_I         = 1'b1;
    WRITE_VALID_I = 1'b0;
    ERR_CLEAR_I   = 1'b0;
    CH_READY_I    = 5'b0;
    #1;
    chk("ready_in_reset", 64'(WRITE_READY_O), 64'(0));
    @(posedge clk);
    #1;
    RST_I = 1'b0;
    pend  = 1'b0;
    pch   = 0;
    age   = 0;
    m_eu  = 1'b0;
    m_et  = 1'b0;
    m_cnt = 0;
    chk("data_after_reset", 64'(CH_DATA_O), 64'(0));
    check_regs();
  endtask

  initial begin
    int h0, r0, v0;
    logic [4:0]  a;
    logic [40:0] d;
    tbl[0] = ADDR_DMI;
    tbl[1] = ADDR_STB0_CS;
    tbl[2] = ADDR_STB0_D;
    tbl[3] = ADDR_STB1_CS;
    tbl[4] = ADDR_STB1_D;
    pdata           = '0;
    WRITE_ADDRESS_I = '0;
    WRITE_DATA_I    = '0;

    do_reset();

    cycle(ADDR_DMI, 41'h1_2345_6789, 1'b1, 5'b00001, 1'b0);
    chk("dmi_valid", 64'(CH_VALID_O), 64'(5'b00001));
    chk("dmi_data", 64'(CH_DATA_O), 64'h1_2345_6789);
    cycle(5'h0, 41'h0, 1'b0, 5'b00001, 1'b0);
    chk("dmi_done_count", 64'(ERR_COUNT_O), 64'(0));

    h0 = dut_hs_count;
    r0 = ready_low;
    for (int i = 0; i < 4; i++) begin
      d = 41'({$urandom(), $urandom()});
      cycle((i % 2 == 1) ? ADDR_STB0_D : ADDR_STB0_CS, d, 1'b1, 5'b00110, 1'b0);
    end
    cycle(5'h0, 41'h0, 1'b0, 5'b00110, 1'b0);
    chk("b2b_handshakes", 64'(dut_hs_count - h0), 64'(4));
    chk("b2b_ready_low", 64'(ready_low - r0), 64'(0));

    cycle(5'h1F, 41'h155, 1'b1, 5'b00000, 1'b0);
    chk("unmapped_flag", 64'(ERR_UNMAPPED_O), 64'(1));
    chk("unmapped_count", 64'(ERR_COUNT_O), 64'(1));
    chk("unmapped_valid", 64'(CH_VALID_O), 64'(0));

    v0 = vhigh;
    cycle(ADDR_STB1_D, 41'h0AB_CDEF_0123, 1'b1, 5'b00000, 1'b0);
    repeat (5) cycle(5'h0, 41'h0, 1'b0, 5'b00000, 1'b0);
    chk("timeout_valid_cycles", 64'(vhigh - v0), 64'(TMO));
    chk("timeout_flag", 64'(ERR_TIMEOUT_O), 64'(1));
    chk("timeout_count", 64'(ERR_COUNT_O), 64'(2));

    cycle(ADDR_STB1_D, 41'h1FF_0000_FFFF, 1'b1, 5'b00000, 1'b0);
    repeat (3) cycle(5'h0, 41'h0, 1'b0, 5'b00000, 1'b0);
    cycle(5'h0, 41'h0, 1'b0, 5'b10000, 1'b0);
    chk("late_ready_valid", 64'(CH_VALID_O), 64'(0));
    chk("late_ready_count", 64'(ERR_COUNT_O), 64'(2));

    cycle(5'h1F, 41'h0, 1'b1, 5'b00000, 1'b1);
    chk("clear_vs_err_flag", 64'(ERR_UNMAPPED_O), 64'(1));
    chk("clear_vs_err_tmo", 64'(ERR_TIMEOUT_O), 64'(0));
    chk("clear_vs_err_count", 64'(ERR_COUNT_O), 64'(1));

    repeat (300) cycle(5'h1F, 41'h0, 1'b1, 5'b00000, 1'b0);
    chk("count_saturated", 64'(ERR_COUNT_O), 64'(255));

    cycle(ADDR_STB1_CS, 41'h123_4567_89AB, 1'b1, 5'b00000, 1'b0);
    cycle(5'h0, 41'h0, 1'b0, 5'b00000, 1'b0);
    do_reset();
    cycle(5'h0, 41'h0, 1'b0, 5'b00000, 1'b0);
    chk("ready_after_reset", 64'(WRITE_READY_O), 64'(1));

    for (int i = 0; i < 500; i++) begin
      a = ($urandom_range(0, 2) != 0) ? tbl[$urandom_range(0, 4)] : 5'($urandom());
      d = 41'({$urandom(), $urandom()});
      cycle(a, d, ($urandom_range(0, 3) != 0), 5'($urandom()) & 5'($urandom()),
            ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_write_router.md
# tap_write_router

Parametrised write router between the UART debug front-end and the debug-register targets (DMI, sticky-byte control/data channels). It decodes each incoming write address against a configurable per-channel address table and registers the payload toward the selected target. It holds valid until the target accepts, and drops stalled writes after a programmable timeout. Unmapped writes and timeouts are recorded in sticky error flags and a saturating error counter, so a dead target can never lock up the front-end.

## Interface
- NUM_CH, 5, number of target channels (1..16)
- WRITE_WIDTH, 41, payload width; wide enough for a full DMI request; narrower targets use the LSBs
- ADDR_WIDTH, IRLENGTH (uart_pkg), address width
- CH_ADDR, {ADDR_DMI, ADDR_STB0_CS, ADDR_STB0_D, ADDR_STB1_CS, ADDR_STB1_D}, packed NUM_CH×ADDR_WIDTH address table; entry k is channel k
- TIMEOUT, 1024, cycles a write may wait for ready; 0 disables the timeout
- CLK_I  in  1  sole clock, rising edge
- RST_I  in  1  synchronous reset, active-high
- WRITE_ADDRESS_I  in  ADDR_WIDTH  target address of the offered write
- WRITE_DATA_I  in  WRITE_WIDTH  write payload
- WRITE_VALID_I  in  1  upstream write valid
- WRITE_READY_O  out  1  upstream write ready
- CH_VALID_O  out  NUM_CH  one-hot per-channel valid
- CH_READY_I  in  NUM_CH  per-channel ready
- CH_DATA_O  out  WRITE_WIDTH  registered payload, shared by all channels
- ERR_CLEAR_I  in  1  clears the sticky flags and the counter
- ERR_UNMAPPED_O  out  1  sticky: a write to an address not in CH_ADDR was accepted
- ERR_TIMEOUT_O  out  1  sticky: a write was dropped by the timeout
- ERR_COUNT_O  out  8  saturating count of both error kinds

## Operation
- FSM states:
  - IDLE: WRITE_READY_O=1, CH_VALID_O=0.
  - SEND: CH_VALID_O=sel (one-hot), CH_DATA_O stable.
- Accept = WRITE_VALID_I && WRITE_READY_O. On accept:
  - Decode the address. If several entries match, the lowest index wins.
  - Hit on channel k: latch the payload into CH_DATA_O, set sel=1<<k, clear the wait counter, go to SEND.
  - Miss: drop the payload, set ERR_UNMAPPED_O, increment ERR_COUNT_O, go to (or stay in) IDLE.
- In SEND, WRITE_READY_O = |(sel & CH_READY_I). This is a combinational path that allows back-to-back writes.
- SEND with a downstream handshake (selected ready high):
  - If a new accept occurs in the same cycle, it is decoded as above: a hit reloads and stays in SEND, a miss flags and goes to IDLE.
  - Otherwise go to IDLE.
- SEND without a handshake: the wait counter increments.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 with no handshake: drop the write, set ERR_TIMEOUT_O, increment ERR_COUNT_O, go to IDLE.
  - No upstream accept occurs in that cycle.
- CH_VALID_O, once asserted, is never deasserted before a handshake or timeout. CH_DATA_O is stable while valid.
- ERR_COUNT_O saturates at 255.
- ERR_CLEAR_I clears the flags and the counter. If clear and a new error occur in the same cycle, the error wins: the flag is 1 and the count is 1.
- Reset values: state IDLE, CH_VALID_O=0, CH_DATA_O=0, sel=0, counter=0, all error outputs 0. WRITE_READY_O=1 from the first cycle after reset. During reset WRITE_READY_O=0.
- Reset during SEND drops the write silently, with no error recorded.

## Timing
- Accept in cycle n → CH_VALID_O high and CH_DATA_O valid in cycle n+1.
- Error flags and the counter update in cycle n+1 after the error event.
- Sustained throughput is 1 write per cycle when the target holds ready high. Otherwise each write completes when its target asserts ready.
- Timeout: with the target never ready, CH_VALID_O is high for exactly TIMEOUT cycles. Ready in the TIMEOUT-th cycle still completes normally.
- Timeout counter width is $clog2(TIMEOUT+1).

## Structure
- uart_pkg holds:
  - IRLENGTH and the ADDR_* constants
  - the enum tap_wr_state_t {IDLE, SEND}
  - the default CH_ADDR table constant
- Sub-module tap_write_watchdog contains the counter, the clear/enable logic and the expire pulse, and is parametrised by TIMEOUT. It is reusable by the read path.

## Test plan
- Write 0x1_2345_6789 to ADDR_DMI with CH_READY_I[0]=1 → CH_VALID_O=5'b00001 one cycle later, CH_DATA_O=0x1_2345_6789, no error.
- Hold ready high on channels 1 and 2; offer 4 consecutive writes alternating ADDR_STB0_CS/ADDR_STB0_D → 4 handshakes in 4 cycles, WRITE_READY_O never low.
- Write to unmapped address 0x1F → accepted immediately, ERR_UNMAPPED_O=1, ERR_COUNT_O=1, CH_VALID_O stays 0.
- With TIMEOUT=4 and CH_READY_I=0: write ADDR_STB1_D → valid high for 4 cycles, then low; ERR_TIMEOUT_O=1 and ERR_COUNT_O increments.
- Repeat with ready asserted in the 4th cycle → normal completion, no error.
- Drive ERR_CLEAR_I in the same cycle as an unmapped write → ERR_UNMAPPED_O=1, ERR_COUNT_O=1.
- Drive 300 unmapped writes → ERR_COUNT_O=255.
- Assert RST_I while in SEND → next cycle CH_VALID_O=0, CH_DATA_O=0, error outputs 0; after release WRITE_READY_O=1.
